jacobi_sweep_ctrl: RTL and testbench

Iteration scheduler for the 5-point Jacobi stencil datapath. It walks the M×M interior of the (M+2)×(M+2) grid and issues one point address per handshake to an external stencil/residual unit. It accumulates the per-point absolute residuals that come back and decides after every sweep whether to converge, stop at the iteration limit, or run another sweep with the ping-pong buffer swapped. It owns sequencing only; grid storage and stencil arithmetic live outside it.

---
 rtl/jacobi_sweep_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_jacobi_sweep_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sweep_ctrl.sv
// Jacobi sweep scheduler: walks the MxM interior, accumulates returned |residual|s and
// decides converge / iteration-limit / next sweep. Define JACOBI_CTRL_REDBLACK_EN for red-black order.
module jacobi_sweep_ctrl #(
    parameter int unsigned M      = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned RES_W  = 48,
    parameter int unsigned ITER_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [RES_W-1:0]  thresh,
    output logic              pt_valid,
    input  logic              pt_ready,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [IDX_W-1:0]  pt_i,
    output logic [IDX_W-1:0]  pt_j,
    output logic              buf_sel,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_abs,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_count,
    output logic [RES_W-1:0]  norm_r
);
    localparam int unsigned NPTS  = M * M;
    localparam int unsigned CNT_W = $clog2(NPTS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NPTS - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(NPTS);
    localparam logic [IDX_W-1:0] I_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] I_M   = IDX_W'(M);

    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, CHECK, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, nxt_i, nxt_j;
    logic [CNT_W-1:0]  iss_q, iss_d, rcv_q, rcv_d;
    logic [RES_W-1:0]  norm_q, norm_d, thr_q, thr_d;
    logic [ITER_W-1:0] iter_q, iter_d, maxit_q, maxit_d, iter_inc;
    logic              conv_q, conv_d, buf_q, buf_d;
    logic              advance, restart_pos;
    logic [RES_W:0]    sum;
`ifdef JACOBI_CTRL_REDBLACK_EN
    localparam logic [IDX_W-1:0] I_TWO = IDX_W'(2);
    localparam logic [IDX_W-1:0] I_MM1 = IDX_W'(M - 1);
    logic ph_q, ph_d, nxt_ph;

    // Step two columns within a colour; at a row end jump to the first same-colour
    // column of the next row, and after the last row switch colour back at row 1.
    always_comb begin
        nxt_ph = ph_q;
        nxt_i  = i_q;
        nxt_j  = j_q + I_TWO;
        if (j_q >= I_MM1) begin
            if (i_q == I_M) begin
                nxt_i  = I_ONE;
                nxt_ph = ~ph_q;
                nxt_j  = ph_q ? I_ONE : I_TWO;
            end else begin
                nxt_i = i_q + I_ONE;
                nxt_j = ((i_q[0] ^ 1'b1) ^ ph_q) ? I_ONE : I_TWO;
            end
        end
    end
`else
    // Raster step; wraps to (1,1) after the last point so the held position stays interior.
    always_comb begin
        nxt_i = i_q;
        nxt_j = j_q + I_ONE;
        if (j_q == I_M) begin
            nxt_j = I_ONE;
            nxt_i = (i_q == I_M) ? I_ONE : i_q + I_ONE;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        iss_d       = iss_q;
        rcv_d       = rcv_q;
        norm_d      = norm_q;
        thr_d       = thr_q;
        iter_d      = iter_q;
        maxit_d     = maxit_q;
        conv_d      = conv_q;
        buf_d       = buf_q;
        advance     = 1'b0;
        restart_pos = 1'b0;
        sum         = {1'b0, norm_q} + {1'b0, res_abs};
        iter_inc    = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d     = SWEEP;
                iter_d      = '0;
                norm_d      = '0;
                iss_d       = '0;
                rcv_d       = '0;
                conv_d      = 1'b0;
                buf_d       = 1'b0;
                maxit_d     = max_iter;
                thr_d       = thresh;
                restart_pos = 1'b1;
            end
            SWEEP: if (pt_ready) begin
                iss_d   = iss_q + CNT_W'(1);
                advance = 1'b1;
                if (iss_q == LAST) state_d = DRAIN;
            end
            DRAIN: if (rcv_q == FULL) state_d = CHECK;
            CHECK: begin
                iter_d = iter_inc;
                if (norm_q <= thr_q) begin
                    conv_d  = 1'b1;
                    state_d = DONE;
                end else if (maxit_q != '0 && iter_inc == maxit_q) begin
                    conv_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    buf_d       = ~buf_q;
                    norm_d      = '0;
                    iss_d       = '0;
                    rcv_d       = '0;
                    restart_pos = 1'b1;
                    state_d     = SWEEP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if ((state_q == SWEEP || state_q == DRAIN) && res_valid && rcv_q != FULL) begin
            norm_d = sum[RES_W] ? '1 : sum[RES_W-1:0];
            rcv_d  = rcv_q + CNT_W'(1);
        end
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            conv_d  = 1'b0;
            iter_d  = iter_q;
            norm_d  = norm_q;
        end
    end

`ifdef JACOBI_CTRL_REDBLACK_EN
    always_comb begin
        ph_d = ph_q;
        if (advance) ph_d = nxt_ph;
        if (restart_pos) ph_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= I_ONE;
            j_q     <= I_ONE;
            iss_q   <= '0;
            rcv_q   <= '0;
            norm_q  <= '0;
            thr_q   <= '0;
            iter_q  <= '0;
            maxit_q <= '0;
            conv_q  <= 1'b0;
            buf_q   <= 1'b0;
`ifdef JACOBI_CTRL_REDBLACK_EN
            ph_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= restart_pos ? I_ONE : (advance ? nxt_i : i_d);
            j_q     <= restart_pos ? I_ONE : (advance ? nxt_j : j_d);
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            norm_q  <= norm_d;
            thr_q   <= thr_d;
            iter_q  <= iter_d;
            maxit_q <= maxit_d;
            conv_q  <= conv_d;
            buf_q   <= buf_d;
`ifdef JACOBI_CTRL_REDBLACK_EN
            ph_q    <= ph_d;
`endif
        end
    end

    assign busy       = (state_q == SWEEP) || (state_q == DRAIN) || (state_q == CHECK);
    assign pt_valid   = (state_q == SWEEP);
    assign done       = (state_q == DONE);
    assign pt_i       = busy ? i_q : '0;
    assign pt_j       = busy ? j_q : '0;
    assign pt_addr    = busy ? ADDR_W'(i_q) * ADDR_W'(M + 2) + ADDR_W'(j_q) : '0;
    assign buf_sel    = buf_q;
    assign converged  = conv_q;
    assign iter_count = iter_q;
    assign norm_r     = norm_q;
endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// Directed bench for jacobi_sweep_ctrl (M=4): raster/red-black walk, iteration limit,
// backpressure, saturation/excess residuals, abort/restart and asynchronous reset.
module tb_jacobi_sweep_ctrl;
    logic        clk, rst_n, start, abort, pt_valid, pt_ready, buf_sel;
    logic        res_valid, busy, done, converged;
    logic [15:0] max_iter, iter_count;
    logic [47:0] thresh, res_abs, norm_r;
    logic [5:0]  pt_addr;
    logic [3:0]  pt_i, pt_j;

    jacobi_sweep_ctrl #(.M(4), .ADDR_W(6), .IDX_W(4), .RES_W(48), .ITER_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .max_iter(max_iter), .thresh(thresh), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_addr(pt_addr), .pt_i(pt_i), .pt_j(pt_j), .buf_sel(buf_sel),
        .res_valid(res_valid), .res_abs(res_abs), .busy(busy), .done(done),
        .converged(converged), .iter_count(iter_count), .norm_r(norm_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp, n_bad, n_xfer, hold_err;
    logic        tog, echo_en, pipe0, pipe1, ok;
    logic [47:0] echo_val;
    logic [5:0]  log_a [64];
    logic        log_b [64];
    logic [5:0]  exp_a [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: log transfers, check address hold under backpressure, echo residuals 2 cycles later.
    task automatic tick();
        logic       x, hv;
        logic [5:0] a;
        x  = pt_valid && pt_ready;
        hv = pt_valid && !pt_ready;
        a  = pt_addr;
        if (x && n_xfer < 64) begin
            log_a[n_xfer] = pt_addr;
            log_b[n_xfer] = buf_sel;
        end
        if (x) n_xfer++;
        @(posedge clk);
        #1;
        if (hv && pt_valid && pt_addr !== a) hold_err++;
        pipe1 = pipe0;
        pipe0 = x && echo_en;
        if (echo_en) begin
            res_valid = pipe1;
            res_abs   = echo_val;
        end
        if (tog) pt_ready = ~pt_ready;
    endtask

    task automatic wait_done(input int lim, output logic found);
        found = 1'b0;
        for (int k = 0; k < lim && !found; k++) begin
            tick();
            if (done) found = 1'b1;
        end
    endtask

    task automatic pulse_start();
        n_xfer = 0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_xfer = 0; hold_err = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter = '0; thresh = '0;
        pt_ready = 1'b1; res_valid = 1'b0; res_abs = '0;
        tog = 1'b0; echo_en = 1'b0; pipe0 = 1'b0; pipe1 = 1'b0; echo_val = '0;
`ifdef JACOBI_CTRL_REDBLACK_EN
        exp_a = '{7, 9, 14, 16, 19, 21, 26, 28, 8, 10, 13, 15, 20, 22, 25, 27};
`else
        exp_a = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};
`endif
        #12;
        chk("rst_pt_valid", pt_valid, 0);
        chk("rst_pt_addr", pt_addr, 0);
        chk("rst_pt_ij", {pt_i, pt_j}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_buf_conv", {buf_sel, converged}, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_norm", norm_r, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single converging sweep, residual 0 echoed 2 cycles after each transfer
        echo_en = 1'b1; echo_val = '0; thresh = '0; max_iter = '0;
        pulse_start();
        chk("first_busy_valid", {busy, pt_valid}, 2'b11);
        chk("first_addr", pt_addr, 7);
        chk("first_ij", {pt_i, pt_j}, 8'h11);
        wait_done(100, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_nxfer", n_xfer, 16);
        for (int k = 0; k < 16; k++) chk($sformatf("t1_addr%0d", k), log_a[k], exp_a[k]);
        chk("t1_conv", converged, 1);
        chk("t1_iter", iter_count, 1);
        chk("t1_norm", norm_r, 0);
        chk("t1_busy_at_done", busy, 0);
        tick();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_idle_addr", {pt_addr, pt_i, pt_j}, 0);

        // Iteration limit: residual 1 per point, 16 > 10 every sweep
        echo_val = 48'd1; thresh = 48'd10; max_iter = 16'd3;
        pulse_start();
        wait_done(300, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_nxfer", n_xfer, 48);
        chk("t2_buf_s1", log_b[0], 0);
        chk("t2_buf_s2", log_b[16], 1);
        chk("t2_buf_s3", log_b[32], 0);
        chk("t2_s3_first_addr", log_a[32], 7);
        chk("t2_s2_last_addr", log_a[31], exp_a[15]);
        chk("t2_conv", converged, 0);
        chk("t2_iter", iter_count, 3);
        chk("t2_norm", norm_r, 16);
        chk("t2_buf_hold", buf_sel, 0);
        tick();

        // Backpressure: pt_ready alternates every cycle
        echo_val = '0; thresh = '0; max_iter = '0; hold_err = 0;
        tog = 1'b1;
        pulse_start();
        wait_done(200, ok);
        tog = 1'b0; pt_ready = 1'b1;
        chk("t3_done_seen", ok, 1);
        chk("t3_nxfer", n_xfer, 16);
        chk("t3_hold_err", hold_err, 0);
        for (int k = 0; k < 16; k++) chk($sformatf("t3_addr%0d", k), log_a[k], exp_a[k]);
        chk("t3_conv_iter", {converged, iter_count}, {1'b1, 16'd1});
        tick();

        // Saturation: two all-ones residuals then 14 small ones, injected in DRAIN
        echo_en = 1'b0; res_valid = 1'b0; thresh = '0; max_iter = 16'd1;
        pulse_start();
        for (int k = 0; k < 16; k++) tick();
        chk("t4_drain_valid", {busy, pt_valid}, 2'b10);
        res_valid = 1'b1; res_abs = '1;
        tick(); tick();
        res_abs = 48'd1;
        for (int k = 0; k < 14; k++) tick();
        res_valid = 1'b0;
        wait_done(20, ok);
        chk("t4_done_seen", ok, 1);
        chk("t4_norm_sat", norm_r, 48'hFFFF_FFFF_FFFF);
        chk("t4_conv_iter", {converged, iter_count}, {1'b0, 16'd1});
        tick();

        // Excess: 17 consecutive residuals of 2; the 17th must be dropped
        pulse_start();
        for (int k = 0; k < 16; k++) tick();
        res_valid = 1'b1; res_abs = 48'd2;
        for (int k = 0; k < 17; k++) tick();
        res_valid = 1'b0;
        wait_done(20, ok);
        chk("t5_done_seen", ok, 1);
        chk("t5_norm", norm_r, 32);
        chk("t5_iter", iter_count, 1);
        tick();

        // Abort while the 5th point of sweep 2 is presented
        echo_en = 1'b1; echo_val = 48'd1; thresh = '0; max_iter = '0;
        pulse_start();
        for (int k = 0; k < 200 && n_xfer < 20; k++) tick();
        chk("t6_reach", n_xfer, 20);
        chk("t6_pt5_addr", {pt_valid, pt_addr}, {1'b1, exp_a[4]});
        chk("t6_sweep2_buf", buf_sel, 1);
        echo_en = 1'b0; pipe0 = 1'b0; pipe1 = 1'b0; res_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_valid_busy", {pt_valid, busy}, 0);
        chk("t6_abort_done", done, 0);
        chk("t6_abort_conv", converged, 0);
        chk("t6_abort_iter_frozen", iter_count, 1);
        chk("t6_abort_addr", pt_addr, 0);
        tick();
        chk("t6_idle_done", {done, busy}, 0);
        pulse_start();
        chk("t6_restart_addr", pt_addr, 7);
        chk("t6_restart_ij", {pt_i, pt_j}, 8'h11);
        chk("t6_restart_iter", iter_count, 0);
        chk("t6_restart_buf_busy", {buf_sel, busy}, 2'b01);
        tick(); tick();

        // Asynchronous reset mid-solve takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("t7_arst_valid_busy", {pt_valid, busy}, 0);
        chk("t7_arst_addr", pt_addr, 0);
        chk("t7_arst_iter_norm", {iter_count, norm_r}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t7_idle_after", {busy, done, pt_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
